// File: rtl/caf_pkg.sv
// rtl/caf_pkg.sv - shared types and width helpers for the CAF datapath
package caf_pkg;

  // FSM states of the correlation MAC frame controller
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Accumulator width: full product sum, one bit for the combine, plus count growth
  function automatic int acc_bits_f(input int i_bits, input int q_bits, input int count_bits);
    return i_bits + q_bits + 1 + count_bits;
  endfunction

endpackage

// File: rtl/xcorr_mac_if.sv
// rtl/xcorr_mac_if.sv - sample-in / correlation-out handshake bundle
interface xcorr_mac_if #(
  parameter int I_BITS     = 12,
  parameter int Q_BITS     = 12,
  parameter int OUT_I_BITS = 12,
  parameter int OUT_Q_BITS = 12
);
  logic                         m_axis_tvalid;
  logic signed [I_BITS-1:0]     xi;
  logic signed [Q_BITS-1:0]     xq;
  logic signed [I_BITS-1:0]     yi;
  logic signed [Q_BITS-1:0]     yq;
  logic                         s_axis_tready;
  logic signed [OUT_I_BITS-1:0] out_i;
  logic signed [OUT_Q_BITS-1:0] out_q;
  logic                         s_axis_tvalid;
  logic                         m_axis_tready;

  // Upstream sample source and downstream result consumer
  modport master (
    output m_axis_tvalid, xi, xq, yi, yq, m_axis_tready,
    input  s_axis_tready, out_i, out_q, s_axis_tvalid
  );

  // The correlation MAC itself
  modport slave (
    input  m_axis_tvalid, xi, xq, yi, yq, m_axis_tready,
    output s_axis_tready, out_i, out_q, s_axis_tvalid
  );
endinterface

// File: rtl/cmult_pipe.sv
// rtl/cmult_pipe.sv - two-stage x*conj(y) complex multiplier with valid passthrough
module cmult_pipe #(
  parameter int W = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic signed [W-1:0]   xi_i,
  input  logic signed [W-1:0]   xq_i,
  input  logic signed [W-1:0]   yi_i,
  input  logic signed [W-1:0]   yq_i,
  output logic                  valid_o,
  output logic signed [2*W:0]   re_o,
  output logic signed [2*W:0]   im_o
);
  localparam int PW = 2 * W;

  logic                 v1_q, v2_q;
  logic signed [PW-1:0] p_ii_q, p_qq_q, p_qi_q, p_iq_q;
  logic signed [PW:0]   re_q, im_q;

  // Stage 1: register the four full-precision partial products
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q   <= 1'b0;
      p_ii_q <= '0;
      p_qq_q <= '0;
      p_qi_q <= '0;
      p_iq_q <= '0;
    end else begin
      v1_q   <= valid_i;
      p_ii_q <= PW'(xi_i) * PW'(yi_i);
      p_qq_q <= PW'(xq_i) * PW'(yq_i);
      p_qi_q <= PW'(xq_i) * PW'(yi_i);
      p_iq_q <= PW'(xi_i) * PW'(yq_i);
    end
  end

  // Stage 2: combine into real/imag of x*conj(y), one bit of growth
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v2_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      v2_q <= v1_q;
      re_q <= (PW+1)'(p_ii_q) + (PW+1)'(p_qq_q);
      im_q <= (PW+1)'(p_qi_q) - (PW+1)'(p_iq_q);
    end
  end

  assign valid_o = v2_q;
  assign re_o    = re_q;
  assign im_o    = im_q;
endmodule

// File: rtl/xcorr_mac.sv
// rtl/xcorr_mac.sv - per-lag complex correlation accumulator feeding the peak search
module xcorr_mac
  import caf_pkg::*;
#(
  parameter int LENGTH     = 10,
  parameter int COUNT_BITS = 4,
  parameter int I_BITS     = 12,
  parameter int Q_BITS     = 12,
  parameter int OUT_I_BITS = 12,
  parameter int OUT_Q_BITS = 12
) (
  input logic        clk,
  input logic        reset,
  xcorr_mac_if.slave bus
);
  localparam int ACC_BITS = acc_bits_f(I_BITS, Q_BITS, COUNT_BITS);
  localparam int P_BITS   = 2 * I_BITS + 1;

  state_e                       state_q, state_d;
  logic [COUNT_BITS-1:0]        cnt_q, cnt_d;
  logic [1:0]                   drain_q, drain_d;
  logic signed [ACC_BITS-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [OUT_I_BITS-1:0] out_i_q, out_i_d;
  logic signed [OUT_Q_BITS-1:0] out_q_q, out_q_d;
  logic                         tvalid_q, tvalid_d, tready_q, tready_d;
  logic                         accept, slot_free, load, v2;
  logic signed [P_BITS-1:0]     re, im;

  assign accept    = bus.m_axis_tvalid & tready_q;
  assign slot_free = !tvalid_q | bus.m_axis_tready;

  cmult_pipe #(.W(I_BITS)) u_cmult (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (accept),
    .xi_i    (bus.xi),
    .xq_i    (bus.xq),
    .yi_i    (bus.yi),
    .yq_i    (bus.yq),
    .valid_o (v2),
    .re_o    (re),
    .im_o    (im)
  );

  // Frame control: count accepts, wait for the pipe to drain, then hand off the result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    load    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == COUNT_BITS'(LENGTH - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
            drain_d = '0;
          end else begin
            cnt_d = cnt_q + COUNT_BITS'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2) begin
          if (slot_free) begin
            load    = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = HOLD;
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Datapath next state: accumulate, floor-truncate into the output slot, track handshake
  always_comb begin
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    out_i_d  = out_i_q;
    out_q_d  = out_q_q;
    tvalid_d = tvalid_q;
    if (load) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (v2) begin
      acc_i_d = acc_i_q + ACC_BITS'(re);
      acc_q_d = acc_q_q + ACC_BITS'(im);
    end
    if (load) begin
      out_i_d  = acc_i_q[ACC_BITS-1 -: OUT_I_BITS];
      out_q_d  = acc_q_q[ACC_BITS-1 -: OUT_Q_BITS];
      tvalid_d = 1'b1;
    end else if (tvalid_q && bus.m_axis_tready) begin
      tvalid_d = 1'b0;
    end
    tready_d = (state_d == ACCUM);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      drain_q  <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      out_i_q  <= '0;
      out_q_q  <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      out_i_q  <= out_i_d;
      out_q_q  <= out_q_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
    end
  end

  assign bus.s_axis_tready = tready_q;
  assign bus.s_axis_tvalid = tvalid_q;
  assign bus.out_i         = out_i_q;
  assign bus.out_q         = out_q_q;
endmodule

// File: tb/tb_xcorr_mac.sv
// tb/tb_xcorr_mac.sv - directed self-checking bench for xcorr_mac
module tb_xcorr_mac;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  xcorr_mac_if #(.I_BITS(12), .Q_BITS(12), .OUT_I_BITS(12), .OUT_Q_BITS(12)) bus ();

  xcorr_mac #(
    .LENGTH(4), .COUNT_BITS(4), .I_BITS(12), .Q_BITS(12),
    .OUT_I_BITS(12), .OUT_Q_BITS(12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int d);
    bus.xi = 12'(a);
    bus.xq = 12'(b);
    bus.yi = 12'(c);
    bus.yq = 12'(d);
  endtask

  task automatic send(input string tag, input int a, input int b, input int c, input int d, input int n);
    int got;
    int guard;
    got   = 0;
    guard = 0;
    drive(a, b, c, d);
    bus.m_axis_tvalid = 1'b1;
    while (got < n && guard < 100) begin
      if (bus.s_axis_tready) got++;
      tick();
      guard++;
    end
    bus.m_axis_tvalid = 1'b0;
    chk({tag, "_accepts"}, got, n);
  endtask

  task automatic run_frame(input string tag, input int a, input int b, input int c, input int d,
                           input int ei, input int eq);
    send(tag, a, b, c, d, 4);
    chk({tag, "_tready_drop"}, 32'(bus.s_axis_tready), 0);
    drive(2047, 2047, 2047, 2047);
    bus.m_axis_tvalid = 1'b1;
    tick();
    tick();
    chk({tag, "_tvalid_e2"}, 32'(bus.s_axis_tvalid), 0);
    bus.m_axis_tvalid = 1'b0;
    tick();
    chk({tag, "_tvalid_e3"}, 32'(bus.s_axis_tvalid), 1);
    chk({tag, "_out_i"}, 32'(bus.out_i), 32'(ei));
    chk({tag, "_out_q"}, 32'(bus.out_q), 32'(eq));
    chk({tag, "_tready_e3"}, 32'(bus.s_axis_tready), 1);
    tick();
    chk({tag, "_tvalid_clear"}, 32'(bus.s_axis_tvalid), 0);
  endtask

  initial begin
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    drive(0, 0, 0, 0);

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_tready", 32'(bus.s_axis_tready), 0);
    chk("rst_tvalid", 32'(bus.s_axis_tvalid), 0);
    chk("rst_out_i", 32'(bus.out_i), 0);
    chk("rst_out_q", 32'(bus.out_q), 0);
    reset = 1'b0;
    tick();
    chk("rst_tready_rise", 32'(bus.s_axis_tready), 1);

    // Main function under several input patterns
    run_frame("real", 1000, 0, 1000, 0, 30, 0);
    run_frame("imag", 0, 1000, 1000, 0, 0, 30);
    run_frame("floor", -1000, 0, 1000, 0, -31, 0);
    run_frame("fullscale", -2048, -2048, -2048, -2048, 256, 0);

    // Backpressure across two frames
    bus.m_axis_tready = 1'b0;
    send("bp_a", 1000, 0, 1000, 0, 4);
    tick();
    tick();
    tick();
    chk("bp_a_tvalid", 32'(bus.s_axis_tvalid), 1);
    chk("bp_a_out_i", 32'(bus.out_i), 30);
    send("bp_b", -1000, 0, 1000, 0, 4);
    drive(2047, 2047, 2047, 2047);
    bus.m_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_hold_tvalid", 32'(bus.s_axis_tvalid), 1);
    chk("bp_hold_out_i", 32'(bus.out_i), 30);
    chk("bp_hold_out_q", 32'(bus.out_q), 0);
    chk("bp_hold_tready", 32'(bus.s_axis_tready), 0);
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    tick();
    bus.m_axis_tready = 1'b0;
    chk("bp_swap_tvalid", 32'(bus.s_axis_tvalid), 1);
    chk("bp_swap_out_i", 32'(bus.out_i), -31);
    chk("bp_swap_out_q", 32'(bus.out_q), 0);
    chk("bp_swap_tready", 32'(bus.s_axis_tready), 1);
    tick();
    chk("bp_stable_tvalid", 32'(bus.s_axis_tvalid), 1);
    chk("bp_stable_out_i", 32'(bus.out_i), -31);
    bus.m_axis_tready = 1'b1;
    tick();
    chk("bp_collect_tvalid", 32'(bus.s_axis_tvalid), 0);

    // Reset mid-frame discards the partial sum
    send("mid", 2047, 0, 2047, 0, 2);
    reset = 1'b1;
    tick();
    chk("mid_rst_tvalid", 32'(bus.s_axis_tvalid), 0);
    chk("mid_rst_tready", 32'(bus.s_axis_tready), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_tready_rise", 32'(bus.s_axis_tready), 1);
    run_frame("after_rst", 1000, 0, 1000, 0, 30, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
